flip_icon_memory: RTL and testbench

//  Storage for the flip-icon table consumed by the flip engine. Accepts a stream of
//  NUM_SPIN-bit flip icons over a valid/ready load port and stores them sequentially

---
 rtl/flip_icon_memory_if.sv | 31 +++
 rtl/flip_icon_memory.sv | 139 +++++++++++++
 tb/tb_flip_icon_memory.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/flip_icon_memory_if.sv
// Load and read ports of the flip-icon table.
// The load side is driven by the table producer and the read side by the flip engine.
interface flip_icon_memory_if #(
    parameter int unsigned NUM_SPIN             = 256,
    parameter int unsigned FLIP_ICON_DEPTH      = 1024,
    parameter int unsigned FLIP_ICON_ADDR_DEPTH = $clog2(FLIP_ICON_DEPTH)
);
    localparam int unsigned CNT_W = FLIP_ICON_ADDR_DEPTH + 1;

    logic                load_start_i;
    logic                icon_valid_i;
    logic [NUM_SPIN-1:0] icon_i;
    logic                icon_last_i;
    logic                icon_ready_o;
    logic                load_done_o;
    logic [CNT_W-1:0]    icon_last_raddr_plus_one_o;
    logic                flip_ren_i;
    logic [CNT_W-1:0]    flip_raddr_i;
    logic [NUM_SPIN-1:0] flip_rdata_o;
    logic                rd_err_o;

    modport master (
        output load_start_i, icon_valid_i, icon_i, icon_last_i, flip_ren_i, flip_raddr_i,
        input  icon_ready_o, load_done_o, icon_last_raddr_plus_one_o, flip_rdata_o, rd_err_o
    );

    modport slave (
        input  load_start_i, icon_valid_i, icon_i, icon_last_i, flip_ren_i, flip_raddr_i,
        output icon_ready_o, load_done_o, icon_last_raddr_plus_one_o, flip_rdata_o, rd_err_o
    );
endinterface

// File: rtl/flip_icon_memory.sv
// Flip-icon table: sequential load over valid/ready, 1-cycle-latency reads once loaded.
// The published icon count doubles as the engine's end-of-table marker.
module flip_icon_memory #(
    parameter int unsigned NUM_SPIN             = 256,
    parameter int unsigned FLIP_ICON_DEPTH      = 1024,
    parameter int unsigned FLIP_ICON_ADDR_DEPTH = $clog2(FLIP_ICON_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              flush_i,
    flip_icon_memory_if.slave bus
);
    localparam int unsigned AW    = FLIP_ICON_ADDR_DEPTH;
    localparam int unsigned CNT_W = FLIP_ICON_ADDR_DEPTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FLIP_ICON_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FLIP_ICON_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    last_q, last_d;
    logic                done_q, done_d;
    logic [NUM_SPIN-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [NUM_SPIN-1:0] mem [FLIP_ICON_DEPTH];

    logic ready_c;
    logic wr_en_c;
    logic rd_legal_c;

    // Icons are accepted only while loading, enabled, and not being restarted or flushed.
    assign ready_c = en_i & ~flush_i & ~bus.load_start_i
                   & (state_q == LOAD) & (count_q < DEPTH_CNT);
    assign wr_en_c = ready_c & bus.icon_valid_i;

    assign rd_legal_c = bus.flip_ren_i & (state_q == DONE) & (bus.flip_raddr_i < count_q);

    // Next-state, count and output-register logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        last_d  = last_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (flush_i) begin
            state_d = IDLE;
            count_d = '0;
            last_d  = '0;
            done_d  = 1'b0;
            rdata_d = '0;
            err_d   = 1'b0;
        end else if (en_i) begin
            err_d = 1'b0;
            if (bus.flip_ren_i) begin
                if (rd_legal_c) begin
                    rdata_d = mem[bus.flip_raddr_i[AW-1:0]];
                end else begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.load_start_i) begin
                        state_d = LOAD;
                        count_d = '0;
                    end
                end
                LOAD: begin
                    if (bus.load_start_i) begin
                        count_d = '0;
                    end else if (wr_en_c) begin
                        count_d = count_q + CNT_W'(1);
                        if (bus.icon_last_i || (count_q == LAST_CNT)) begin
                            state_d = DONE;
                            last_d  = count_q + CNT_W'(1);
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.load_start_i) begin
                        state_d = LOAD;
                        count_d = '0;
                        last_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    last_d  = '0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Table storage is intentionally not reset; stale contents are unreachable via count.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem[count_q[AW-1:0]] <= bus.icon_i;
        end
    end

    assign bus.icon_ready_o               = ready_c;
    assign bus.load_done_o                = done_q;
    assign bus.icon_last_raddr_plus_one_o = last_q;
    assign bus.flip_rdata_o               = rdata_q;
    assign bus.rd_err_o                   = err_q;
endmodule

// File: tb/tb_flip_icon_memory.sv
// Directed bench for flip_icon_memory on a small 32-bit x 16-entry configuration.
module tb_flip_icon_memory;
    localparam int unsigned NS    = 32;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] fl, en, ls, v, icon, last, ren, raddr;
        logic [31:0] e_ready, e_done, e_cnt, e_rdata, e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flip_icon_memory_if #(.NUM_SPIN(NS), .FLIP_ICON_DEPTH(DEPTH)) bus ();

    flip_icon_memory #(.NUM_SPIN(NS), .FLIP_ICON_DEPTH(DEPTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (en),
        .flush_i(flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic vec_t mk(input logic [31:0] fl, en_v, ls, v, icon, last, ren, raddr,
                                input logic [31:0] er, ed, ec, erd, ee);
        vec_t t;
        t.fl = fl; t.en = en_v; t.ls = ls; t.v = v; t.icon = icon; t.last = last;
        t.ren = ren; t.raddr = raddr;
        t.e_ready = er; t.e_done = ed; t.e_cnt = ec; t.e_rdata = erd; t.e_err = ee;
        return t;
    endfunction

    task automatic chk(input string what, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d: got %h want %h", what, idx, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check ready before the edge, registers after.
    task automatic apply(input vec_t t, input string tag, input int idx);
        @(negedge clk);
        flush              = t.fl[0];
        en                 = t.en[0];
        bus.load_start_i   = t.ls[0];
        bus.icon_valid_i   = t.v[0];
        bus.icon_i         = t.icon;
        bus.icon_last_i    = t.last[0];
        bus.flip_ren_i     = t.ren[0];
        bus.flip_raddr_i   = t.raddr[4:0];
        #1;
        chk({tag, ".ready"}, idx, 32'(bus.icon_ready_o), t.e_ready);
        @(posedge clk);
        #1;
        chk({tag, ".done"}, idx, 32'(bus.load_done_o), t.e_done);
        chk({tag, ".count"}, idx, 32'(bus.icon_last_raddr_plus_one_o), t.e_cnt);
        chk({tag, ".rdata"}, idx, bus.flip_rdata_o, t.e_rdata);
        chk({tag, ".rd_err"}, idx, 32'(bus.rd_err_o), t.e_err);
    endtask

    vec_t tbl [20];
    logic [31:0] ia, ib, ic, id, ie, iy, iz;

    initial begin
        ia = 32'hAAAA_0001; ib = 32'hAAAA_0002; ic = 32'hAAAA_0003; id = 32'hAAAA_0004;
        ie = 32'hAAAA_0005; iy = 32'hAAAA_0006; iz = 32'hAAAA_0009;
        //            fl en ls v  icon last ren addr  rdy done cnt rdata err
        tbl[0]  = mk(0, 1, 1, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0);
        tbl[1]  = mk(0, 1, 0, 1, ia, 0, 0, 0,   1, 0, 0, 0,  0);
        tbl[2]  = mk(0, 1, 0, 1, ib, 0, 0, 0,   1, 0, 0, 0,  0);
        tbl[3]  = mk(0, 1, 0, 1, ic, 0, 0, 0,   1, 0, 0, 0,  0);
        tbl[4]  = mk(0, 1, 0, 1, id, 1, 0, 0,   1, 1, 4, 0,  0);
        tbl[5]  = mk(0, 1, 0, 0, 0,  0, 1, 2,   0, 1, 4, ic, 0);
        tbl[6]  = mk(0, 1, 0, 0, 0,  0, 1, 4,   0, 1, 4, 0,  1);
        tbl[7]  = mk(0, 1, 0, 0, 0,  0, 1, 3,   0, 1, 4, id, 0);
        tbl[8]  = mk(0, 1, 0, 0, 0,  0, 0, 0,   0, 1, 4, id, 0);
        tbl[9]  = mk(0, 1, 1, 0, 0,  0, 1, 0,   0, 0, 0, ia, 0);
        tbl[10] = mk(0, 1, 0, 1, ie, 1, 1, 0,   1, 1, 1, 0,  1);
        tbl[11] = mk(0, 1, 0, 0, 0,  0, 1, 0,   0, 1, 1, ie, 0);
        tbl[12] = mk(0, 1, 0, 0, 0,  0, 1, 1,   0, 1, 1, 0,  1);
        tbl[13] = mk(1, 1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,  0);
        tbl[14] = mk(0, 1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0,  1);
        tbl[15] = mk(0, 1, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0);
        tbl[16] = mk(0, 1, 1, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0);
        tbl[17] = mk(0, 0, 0, 1, iz, 1, 1, 0,   0, 0, 0, 0,  0);
        tbl[18] = mk(0, 1, 0, 1, iy, 1, 0, 0,   1, 1, 1, 0,  0);
        tbl[19] = mk(0, 1, 0, 0, 0,  0, 1, 0,   0, 1, 1, iy, 0);

        bus.load_start_i = 1'b0; bus.icon_valid_i = 1'b0; bus.icon_i = '0;
        bus.icon_last_i = 1'b0; bus.flip_ren_i = 1'b0; bus.flip_raddr_i = '0;

        // Reset values while reset is held
        #12;
        chk("reset.ready", 0, 32'(bus.icon_ready_o), 0);
        chk("reset.done", 0, 32'(bus.load_done_o), 0);
        chk("reset.count", 0, 32'(bus.icon_last_raddr_plus_one_o), 0);
        chk("reset.rdata", 0, bus.flip_rdata_o, 0);
        chk("reset.rd_err", 0, 32'(bus.rd_err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) apply(tbl[i], "tbl", i);

        // Flush and restart in the middle of a load
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "t5", 0);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "t5", 1);
        for (int k = 0; k < 3; k++)
            apply(mk(0, 1, 0, 1, f(k), 0, 0, 0,  1, 0, 0, 0, 0), "t5", 2 + k);
        apply(mk(1, 1, 0, 1, f(7), 0, 0, 0,  0, 0, 0, 0, 0), "t5", 5);
        apply(mk(0, 1, 0, 1, f(8), 0, 0, 0,  0, 0, 0, 0, 0), "t5", 6);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "t5", 7);
        apply(mk(0, 1, 0, 1, f(20), 0, 0, 0,  1, 0, 0, 0, 0), "t5", 8);
        apply(mk(0, 1, 0, 1, f(21), 0, 0, 0,  1, 0, 0, 0, 0), "t5", 9);
        apply(mk(0, 1, 0, 1, f(22), 0, 0, 0,  1, 0, 0, 0, 0), "t5", 10);
        apply(mk(0, 1, 1, 1, f(30), 0, 0, 0,  0, 0, 0, 0, 0), "t5", 11);
        apply(mk(0, 1, 0, 1, f(23), 1, 0, 0,  1, 1, 1, 0, 0), "t5", 12);
        apply(mk(0, 1, 0, 0, 0, 0, 1, 0,  0, 1, 1, f(23), 0), "t5", 13);
        apply(mk(0, 1, 0, 0, 0, 0, 1, 1,  0, 1, 1, 0, 1), "t5", 14);

        // Fill to capacity without icon_last
        apply(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "t2", 100);
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), "t2", 101);
        for (int i = 0; i < int'(DEPTH); i++)
            apply(mk(0, 1, 0, 1, f(i), 0, 0, 0,  1, (i == 15) ? 1 : 0, (i == 15) ? 16 : 0, 0, 0),
                  "t2", i);
        apply(mk(0, 1, 0, 1, f(99), 0, 0, 0,  0, 1, 16, 0, 0), "t2", 102);

        // Back-to-back reads, then the top legal address and the first illegal one
        for (int a = 0; a < 10; a++)
            apply(mk(0, 1, 0, 0, 0, 0, 1, a,  0, 1, 16, f(a), 0), "t4", a);
        apply(mk(0, 1, 0, 0, 0, 0, 1, 15,  0, 1, 16, f(15), 0), "t4", 15);
        apply(mk(0, 1, 0, 0, 0, 0, 1, 16,  0, 1, 16, 0, 1), "t4", 16);
        apply(mk(0, 1, 0, 0, 0, 0, 1, 3,  0, 1, 16, f(3), 0), "t4", 3);

        // Disabled: everything frozen even with start, valid and read asserted
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 1, 1, f(50), 1, 1, 9,  0, 1, 16, f(3), 0), "t6", i);
        apply(mk(0, 1, 0, 0, 0, 0, 1, 4,  0, 1, 16, f(4), 0), "t6", 5);

        // Asynchronous reset pulse between clock edges
        @(negedge clk);
        en = 1'b0;
        bus.flip_ren_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6rst.ready", 0, 32'(bus.icon_ready_o), 0);
        chk("t6rst.done", 0, 32'(bus.load_done_o), 0);
        chk("t6rst.count", 0, 32'(bus.icon_last_raddr_plus_one_o), 0);
        chk("t6rst.rdata", 0, bus.flip_rdata_o, 0);
        chk("t6rst.rd_err", 0, 32'(bus.rd_err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(0, 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1), "t6", 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
